vga_tile_renderer: RTL and testbench
====================================

// Module: vga_tile_renderer
// PURPOSE
//   Pixel stage directly downstream of the VGA timing generator.
//   - Consumes the generator's x/y, valid, hsync/vsync and pixclk strobe.
//   - Fetches an 8x8-tile character map and a 1bpp tile-pattern ROM, both external synchronous memories.
//   - Resolves each pixel through a 16-entry 12-bit palette.
//   - Drives registered 4:4:4 RGB plus hsync/vsync delayed to stay aligned with the colour data.
// PARAMETERS
//   MAP_COLS   80  tiles per map row; map_addr = (y>>3)*MAP_COLS + (x>>3)
//   BLINK_BIT  5   frame_cnt bit that gates cursor blink (period 2^(BLINK_BIT+1) frames)
// PORTS
//   clk        in   1   system clock (pixclk strobe is high 1 of every 2 cycles)
//   rst_n      in   1   asynchronous, active-low reset
//   x, y       in   10  pixel coordinates from the timing generator
//   valid      in   1   active-area flag
//   hsync      in   1   active-low horizontal sync
//   vsync      in   1   active-low vertical sync
//   newframe   in   1   1-cycle pulse at frame wrap
//   pixclk     in   1   1-cycle pixel-advance strobe
//   map_addr   out  13  tile-map RAM address (registered)
//   map_data   in   16  [7:0] tile index, [11:8] fg palette index, [15:12] bg palette index; 1-clk read latency
//   pat_addr   out  11  pattern ROM address {tile[7:0], row[2:0]} (registered)
//   pat_data   in   8   pattern row; bit 7 = leftmost pixel; 1-clk read latency
//   pal_we     in   1   palette write enable
//   pal_addr   in   4   palette write index
//   pal_data   in   12  palette write value {R[3:0], G[3:0], B[3:0]}
//   cur_x      in   7   cursor tile column (used only with CURSOR_EN)
//   cur_y      in   6   cursor tile row (used only with CURSOR_EN)
//   red/green/blue out 4 each  pixel colour (registered)
//   hsync_o, vsync_o  out  1   delayed syncs (registered)
//   de         out  1   delayed valid
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//       - map_addr, pat_addr, rgb, de, frame_cnt, all pipeline regs = 0.
//       - hsync_o = vsync_o = 1.
//       - Palette entry i = {i,i,i} (grey ramp).
//   - Pipeline advances only on clk edges where pixclk=1; all regs hold otherwise. Latency is exactly 2 strobes.
//   - Strobe k (S1):
//       - Capture x[2:0], y[2:0], valid, hsync, vsync into stage 1.
//       - If valid=1, map_addr <= (y>>3)*MAP_COLS + (x>>3); if valid=0, map_addr holds its previous value.
//   - Strobe k+1 (S2):
//       - pat_addr <= {map_data[7:0], s1_row}.
//       - Latch fg/bg indices and stage-1 sideband into stage 2.
//   - Strobe k+2 (S3):
//       - bit = pat_data[7 - s2_col]; idx = bit ? fg : bg.
//       - {red,green,blue} <= de_next ? palette[idx] : 12'h000.
//       - hsync_o, vsync_o, de <= stage-2 values.
//   - The 2-clk gap between strobes covers the 1-clk memory latency; sampling happens on the strobe edge.
//   - Palette:
//       - Write occurs on any clk with pal_we=1, independent of pixclk.
//       - A read on the same edge as a write to the same index returns the old value.
//   - frame_cnt:
//       - 8 bits, +1 on each newframe pulse, wraps 255->0.
//       - A newframe pulse coincident with reset release is ignored.
//   - Reset mid-frame: outputs go blank/idle immediately. After release, the first valid colour appears 2 strobes after the first strobe.
// CONFIGURATION
//   - CURSOR_EN defined: a pixel is inverted (idx = bit ? bg : fg) when all of the following hold:
//       - its tile equals (cur_x, cur_y);
//       - its tile row is 7;
//       - frame_cnt[BLINK_BIT] = 1.
//     cur_x/cur_y are sampled at S1 with the pixel.
//   - CURSOR_EN undefined: cur_x/cur_y are ignored, no inversion logic is built, and frame_cnt may be optimised away.
// TESTING
//   - Reset: rst_n=0 mid-line -> rgb=0, de=0, hsync_o=vsync_o=1 asynchronously; palette[5] reads 12'h555.
//   - Pipeline timing:
//       - Stimulus: map_data=16'h2100 at tile (0,0); pat_data=8'h80; pal[1]=12'hF00; pal[2]=12'h00F.
//       - Response: pixel (0,0) = 12'hF00 and pixel (1,0) = 12'h00F, each 2 strobes after the input; map_addr = 0 then 1 at x=8.
//   - Addressing: x=639, y=479 with valid=1 -> map_addr = 59*80+79 = 4799; then valid=0 at x=640 -> map_addr holds 4799 and rgb=0.
//   - Sync alignment: hsync falls at x=656 -> hsync_o falls exactly 2 strobes (4 clk) later, coincident with de/rgb of the same pixel.
//   - Palette hazard: pal_we at pal_addr=3 on the same edge as S3 of a pixel using index 3 -> old colour output; the next pixel shows the new value.
//   - CURSOR_EN: cur=(2,1), frame_cnt[5]=1 -> pixels x=16..23, y=15 use swapped fg/bg; with frame_cnt[5]=0, or the macro undefined, output is unchanged.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel renderer: map fetch -> pattern fetch -> palette lookup, 2 pixel strobes of latency.
// Optional cursor-blink inversion is built only when CURSOR_EN is defined.
module vga_tile_renderer #(
    parameter int MAP_COLS  = 80,
    parameter int BLINK_BIT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        newframe,
    input  logic        pixclk,
    output logic [12:0] map_addr,
    input  logic [15:0] map_data,
    output logic [10:0] pat_addr,
    input  logic [7:0]  pat_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    input  logic [6:0]  cur_x,
    input  logic [5:0]  cur_y,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de
);

    logic [11:0] palette [16];

    logic [2:0]  s1_col;
    logic [2:0]  s1_row;
    logic        s1_valid;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_cur;

    logic [2:0]  s2_col;
    logic [3:0]  s2_fg;
    logic [3:0]  s2_bg;
    logic        s2_valid;
    logic        s2_hs;
    logic        s2_vs;
    logic        s2_cur;

    logic [12:0] tile_addr;
    logic        cur_hit;
    logic        pix_bit;
    logic [3:0]  pix_idx;

    assign tile_addr = 13'(y[9:3]) * 13'(MAP_COLS) + 13'(x[9:3]);
    assign pix_bit   = pat_data[3'd7 - s2_col];
    assign pix_idx   = (pix_bit ^ s2_cur) ? s2_fg : s2_bg;

`ifdef CURSOR_EN
    logic [7:0] frame_cnt;
    logic       armed;

    // armed drops the newframe pulse that lands on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (newframe && armed)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign cur_hit = (x[9:3] == cur_x) && (y[9:3] == {1'b0, cur_y}) &&
                     (y[2:0] == 3'd7) && frame_cnt[BLINK_BIT];
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_x, cur_y, newframe};
    assign cur_hit       = 1'b0;
`endif

    // Palette writes ignore pixclk; a same-edge read sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                palette[i] <= {4'(i), 4'(i), 4'(i)};
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    // Sync stages reset to the idle (high) level so no spurious pulse leaves after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col   <= 3'd0;
            s1_row   <= 3'd0;
            s1_valid <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_cur   <= 1'b0;
            map_addr <= 13'd0;
        end else if (pixclk) begin
            s1_col   <= x[2:0];
            s1_row   <= y[2:0];
            s1_valid <= valid;
            s1_hs    <= hsync;
            s1_vs    <= vsync;
            s1_cur   <= cur_hit;
            if (valid)
                map_addr <= tile_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_col   <= 3'd0;
            s2_fg    <= 4'd0;
            s2_bg    <= 4'd0;
            s2_valid <= 1'b0;
            s2_hs    <= 1'b1;
            s2_vs    <= 1'b1;
            s2_cur   <= 1'b0;
            pat_addr <= 11'd0;
        end else if (pixclk) begin
            s2_col   <= s1_col;
            s2_fg    <= map_data[11:8];
            s2_bg    <= map_data[15:12];
            s2_valid <= s1_valid;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_cur   <= s1_cur;
            pat_addr <= {map_data[7:0], s1_row};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {red, green, blue} <= 12'h000;
            de                 <= 1'b0;
            hsync_o            <= 1'b1;
            vsync_o            <= 1'b1;
        end else if (pixclk) begin
            {red, green, blue} <= s2_valid ? palette[pix_idx] : 12'h000;
            de                 <= s2_valid;
            hsync_o            <= s2_hs;
            vsync_o            <= s2_vs;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: behavioural map/pattern memories and a
// scoreboard of expected {de, hsync, vsync, palette index} entries, two strobes deep.
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        valid = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        newframe = 1'b0;
    logic        pixclk = 1'b0;
    logic [12:0] map_addr;
    logic [15:0] map_data;
    logic [10:0] pat_addr;
    logic [7:0]  pat_data;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;
    logic [6:0]  cur_x = '0;
    logic [5:0]  cur_y = '0;
    logic [3:0]  red, green, blue;
    logic        hsync_o, vsync_o, de;

    logic [15:0] map_mem [8192];
    logic [7:0]  pat_mem [2048];
    logic [11:0] pal_model [16];
    logic [11:0] pal_old [16];
    logic [7:0]  fc_model;
    logic [6:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .valid(valid),
        .hsync(hsync), .vsync(vsync), .newframe(newframe), .pixclk(pixclk),
        .map_addr(map_addr), .map_data(map_data), .pat_addr(pat_addr), .pat_data(pat_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .cur_x(cur_x), .cur_y(cur_y),
        .red(red), .green(green), .blue(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de(de)
    );

    // Synchronous memories with one clock of read latency
    always @(posedge clk) begin
        map_data <= map_mem[map_addr];
        pat_data <= pat_mem[pat_addr];
    end

    function automatic logic [6:0] model(input int px, input int py, input logic pv,
                                         input logic phs, input logic pvs);
        logic [15:0] m;
        logic [7:0]  p;
        logic        b;
        logic        inv;
        logic [3:0]  idx;
        m   = map_mem[13'((py / 8) * 80 + px / 8)];
        p   = pat_mem[{m[7:0], 3'(py % 8)}];
        b   = p[3'(7 - px % 8)];
        inv = 1'b0;
`ifdef CURSOR_EN
        inv = (px / 8 == int'(cur_x)) && (py / 8 == int'(cur_y)) && (py % 8 == 7) && fc_model[5];
`endif
        idx = (b ^ inv) ? m[11:8] : m[15:12];
        return {pv, phs, pvs, pv ? idx : 4'h0};
    endfunction

    task automatic drive_pixel(input int px, input int py, input logic pv, input logic phs,
                               input logic pvs, input logic pwe, input logic [3:0] pwa,
                               input logic [11:0] pwd);
        logic [6:0]  e;
        logic [11:0] er;
        exp_q.push_back(model(px, py, pv, phs, pvs));
        x = 10'(px); y = 10'(py); valid = pv; hsync = phs; vsync = pvs;
        pixclk = 1'b1; pal_we = pwe; pal_addr = pwa; pal_data = pwd;
        pal_old = pal_model;
        if (pwe) pal_model[pwa] = pwd;
        @(posedge clk); #1;
        pixclk = 1'b0; pal_we = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: queue empty at pixel (%0d,%0d)", px, py);
        end else begin
            e  = exp_q.pop_front();
            er = e[6] ? pal_old[e[3:0]] : 12'h000;
            if ({de, hsync_o, vsync_o, red, green, blue} !== {e[6:4], er})
                $display("FAIL pixel_out at input (%0d,%0d): de/hs/vs/rgb got %b%b%b/%h want %b/%h",
                         px, py, de, hsync_o, vsync_o, {red, green, blue}, e[6:4], er);
            else
                n_pass++;
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic pix(input int px, input int py, input logic pv);
        drive_pixel(px, py, pv, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    endtask

    task automatic flush();
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
    endtask

    task automatic write_pal(input logic [3:0] a, input logic [11:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        @(posedge clk); #1;
        pal_we = 1'b0;
        pal_model[a] = d;
        @(negedge clk);
    endtask

    task automatic pulse_newframe();
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
        fc_model = fc_model + 8'd1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({de, hsync_o, vsync_o, red, green, blue} !== {3'b011, 12'h000})
            $display("FAIL reset_outputs: de/hs/vs/rgb got %b%b%b/%h want 011/000",
                     de, hsync_o, vsync_o, {red, green, blue});
        else
            n_pass++;
        n_checks++;
        if ({map_addr, pat_addr} !== 24'h0)
            $display("FAIL reset_addr: map_addr %0d pat_addr %0d want 0/0", map_addr, pat_addr);
        else
            n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(7'b0110000);
        exp_q.push_back(7'b0110000);
        for (int i = 0; i < 16; i++) pal_model[i] = {4'(i), 4'(i), 4'(i)};
        fc_model = 8'd0;
    endtask

    task automatic test_reset();
        do_reset();
        map_mem[0] = 16'h0502;
        pat_mem[{8'd2, 3'd0}] = 8'hFF;
        for (int i = 0; i < 4; i++) pix(i, 0, 1'b1);
        @(posedge clk); #2;
        do_reset();
        pix(0, 0, 1'b1);
        pix(1, 0, 1'b0);
        n_checks++;
        if (de !== 1'b0) $display("FAIL early_de: got %b want 0", de); else n_pass++;
        pix(2, 0, 1'b0);
        n_checks++;
        if ({de, red, green, blue} !== {1'b1, 12'h555})
            $display("FAIL pal5_grey: de/rgb got %b/%h want 1/555", de, {red, green, blue});
        else
            n_pass++;
        flush();
    endtask

    task automatic test_pipeline();
        map_mem[0] = 16'h2100;
        map_mem[1] = 16'h0000;
        pat_mem[0] = 8'h80;
        write_pal(4'd1, 12'hF00);
        write_pal(4'd2, 12'h00F);
        for (int px = 0; px < 10; px++) begin
            pix(px, 0, 1'b1);
            if (px == 0 || px == 8) begin
                n_checks++;
                if (map_addr !== 13'(px / 8))
                    $display("FAIL map_addr_x%0d: got %0d want %0d", px, map_addr, px / 8);
                else
                    n_pass++;
            end
            if (px == 2 || px == 3) begin
                n_checks++;
                if ({red, green, blue} !== ((px == 2) ? 12'hF00 : 12'h00F))
                    $display("FAIL latency_x%0d: rgb got %h", px - 2, {red, green, blue});
                else
                    n_pass++;
            end
        end
        flush();
    endtask

    task automatic test_addressing();
        pix(639, 479, 1'b1);
        n_checks++;
        if (map_addr !== 13'd4799) $display("FAIL addr_last: got %0d want 4799", map_addr); else n_pass++;
        pix(640, 479, 1'b0);
        n_checks++;
        if (map_addr !== 13'd4799) $display("FAIL addr_hold: got %0d want 4799", map_addr); else n_pass++;
        pix(641, 479, 1'b0);
        pix(642, 479, 1'b0);
        n_checks++;
        if ({de, red, green, blue} !== 13'h0)
            $display("FAIL blank_rgb: de/rgb got %b/%h want 0/000", de, {red, green, blue});
        else
            n_pass++;
    endtask

    task automatic test_sync();
        for (int px = 652; px < 663; px++) begin
            drive_pixel(px, 10, 1'b0, (px < 656), 1'b1, 1'b0, 4'h0, 12'h000);
            if (px == 657 || px == 658) begin
                n_checks++;
                if (hsync_o !== (px == 657))
                    $display("FAIL hsync_align_x%0d: got %b want %b", px, hsync_o, px == 657);
                else
                    n_pass++;
            end
        end
        flush();
    endtask

    task automatic test_palette_hazard();
        map_mem[160] = 16'h0301;
        pat_mem[{8'd1, 3'd0}] = 8'hFF;
        pix(0, 16, 1'b1);
        pix(1, 16, 1'b1);
        drive_pixel(2, 16, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 12'hABC);
        n_checks++;
        if ({red, green, blue} !== 12'h333) $display("FAIL hazard_old: got %h want 333", {red, green, blue}); else n_pass++;
        pix(3, 16, 1'b1);
        n_checks++;
        if ({red, green, blue} !== 12'hABC) $display("FAIL hazard_new: got %h want abc", {red, green, blue}); else n_pass++;
        flush();
    endtask

    task automatic test_cursor();
        logic [11:0] want;
        cur_x = 7'd2; cur_y = 6'd1;
        map_mem[82] = 16'h4501;
        pat_mem[{8'd1, 3'd7}] = 8'hF0;
        pat_mem[{8'd1, 3'd6}] = 8'h0F;
        for (int px = 14; px < 26; px++) pix(px, 15, 1'b1);
        flush();
        for (int i = 0; i < 32; i++) pulse_newframe();
        for (int py = 14; py < 16; py++)
            for (int px = 14; px < 26; px++) begin
                pix(px, py, 1'b1);
                if (py == 15 && px == 18) begin
`ifdef CURSOR_EN
                    want = 12'h444;
`else
                    want = 12'h555;
`endif
                    n_checks++;
                    if ({red, green, blue} !== want)
                        $display("FAIL cursor_x16: got %h want %h", {red, green, blue}, want);
                    else
                        n_pass++;
                end
            end
        flush();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8192; i++) map_mem[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) pat_mem[i] = 8'($urandom);
        for (int i = 0; i < 300; i++) begin
            cur_x = 7'($urandom_range(0, 79));
            cur_y = 6'($urandom_range(0, 59));
            drive_pixel($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0), 4'($urandom), 12'($urandom));
        end
        flush();
    endtask

    task automatic test_back_to_back();
        for (int px = 100; px < 106; px++) pix(px, 40, 1'b1);
        do_reset();
        for (int px = 0; px < 12; px++) pix(px + 200, 41, 1'b1);
        flush();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) map_mem[i] = 16'h0;
        for (int i = 0; i < 2048; i++) pat_mem[i] = 8'h0;
        fc_model = 8'd0;
        test_reset();
        test_pipeline();
        test_addressing();
        test_sync();
        test_palette_hazard();
        test_cursor();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
